// File: rtl/afifo_rd_packer.sv
// rtl/afifo_rd_packer.sv - packs show-ahead FIFO words into wide valid/ready beats
// Optional accepted-beat counter port beat_cnt is built when AFIFO_PACK_STAT_EN is defined.
module afifo_rd_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int PACK_RATIO = 4,
  parameter int CNT_W      = 3
) (
  input  logic                             CLK,
  input  logic                             RST_X,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             fifo_deq,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [CNT_W-1:0]                 out_count,
  output logic                             out_last
`ifdef AFIFO_PACK_STAT_EN
  ,
  output logic [15:0]                      beat_cnt
`endif
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACK_RATIO - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_RATIO);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  last_q, last_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [DATA_WIDTH-1:0] slot_q [PACK_RATIO];
  logic [DATA_WIDTH-1:0] slot_d [PACK_RATIO];
  logic                  flush_any;

  assign flush_any = flush | flush_pend_q;
  assign fifo_deq  = RST_X & (state_q == FILL) & ~fifo_empty & ~flush_any;
  assign out_valid = (state_q == HOLD);
  assign out_count = count_q;
  assign out_last  = last_q;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < PACK_RATIO; k++) begin
      out_data[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    count_d      = count_q;
    last_d       = last_q;
    flush_pend_d = flush_pend_q;
    slot_d       = slot_q;
    case (state_q)
      FILL: begin
        if (fifo_deq) begin
          for (int k = 0; k < PACK_RATIO; k++) begin
            if (cnt_q == CNT_W'(k)) slot_d[k] = fifo_data;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = HOLD;
            count_d = FULL_CNT;
            last_d  = 1'b0;
          end
        end else if (flush_any) begin
          // An empty accumulator swallows the flush without emitting a beat
          flush_pend_d = 1'b0;
          if (cnt_q != '0) begin
            state_d = HOLD;
            count_d = cnt_q;
            last_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (flush) flush_pend_d = 1'b1;
        if (out_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          count_d = '0;
          last_d  = 1'b0;
          for (int k = 0; k < PACK_RATIO; k++) slot_d[k] = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      count_q      <= '0;
      last_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      for (int k = 0; k < PACK_RATIO; k++) slot_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      last_q       <= last_d;
      flush_pend_q <= flush_pend_d;
      slot_q       <= slot_d;
    end
  end

`ifdef AFIFO_PACK_STAT_EN
  logic [15:0] beat_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      beat_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_afifo_rd_packer.sv
// tb/tb_afifo_rd_packer.sv - directed and randomized checks of afifo_rd_packer
// Builds with or without AFIFO_PACK_STAT_EN.
module tb_afifo_rd_packer;
  localparam int DW = 32;
  localparam int PR = 4;
  localparam int CW = 3;
  localparam int W  = DW * PR;

  logic          CLK = 1'b0;
  logic          RST_X = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_deq;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_last;
`ifdef AFIFO_PACK_STAT_EN
  logic [15:0]   beat_cnt;
`endif

  always #5 CLK = ~CLK;

  afifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_X(RST_X), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_deq(fifo_deq), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_last(out_last)
`ifdef AFIFO_PACK_STAT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sent_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            acc_total = 0;
  bit            rand_mode = 1'b0;
  logic          s_deq, s_valid, s_last, s_acc;
  logic [W-1:0]  s_data;
  logic [CW-1:0] s_count;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] pack4(input logic [DW-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    if (rand_mode) sent_q.push_back(w);
  endtask

  // Every accepted beat must carry the next out_count words in send order, zeros above.
  task automatic score_beat();
    int n;
    logic [W-1:0] exp;
    n = int'(s_count);
    check("rand_count_range", W'(n >= 1 && n <= PR), W'(1));
    check("rand_last", W'(s_last), W'(n != PR));
    if (n > PR) n = PR;
    exp = '0;
    for (int k = 0; k < n; k++) begin
      if (sent_q.size() > 0) begin
        exp[k*DW +: DW] = sent_q[0];
        void'(sent_q.pop_front());
      end
    end
    check("rand_data", s_data, exp);
  endtask

  task automatic tick();
    fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() > 0) fifo_data = fifo_q[0];
    else fifo_data = '0;
    #1;
    s_deq   = fifo_deq;
    s_valid = out_valid;
    s_data  = out_data;
    s_count = out_count;
    s_last  = out_last;
    s_acc   = out_valid && out_ready;
    if (rand_mode && s_acc) score_beat();
    @(posedge CLK);
    if (s_deq === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (!RST_X) acc_total = 0;
    else if (s_acc) acc_total++;
    @(negedge CLK);
  endtask

  initial begin
    int guard;

    // Reset holds off pops even with data waiting
    out_ready = 1'b1;
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    repeat (3) begin
      tick();
      check("rst_deq", W'(s_deq), W'(0));
    end
    RST_X = 1'b1;
    tick();
    check("rst_valid", W'(s_valid), W'(0));
    check("rst_data", s_data, W'(0));
    check("rst_count", W'(s_count), W'(0));
    check("rst_last", W'(s_last), W'(0));
    check("t2_deq0", W'(s_deq), W'(1));

    // Full beat
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t2_deq", W'(s_deq), W'(1));
    end
    tick();
    check("t2_valid", W'(s_valid), W'(1));
    check("t2_data", s_data, pack4(32'h11, 32'h22, 32'h33, 32'h44));
    check("t2_count", W'(s_count), W'(4));
    check("t2_last", W'(s_last), W'(0));
    tick();
    check("t2_valid_drop", W'(s_valid), W'(0));

    // Flush with nothing accumulated emits no beat
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("t5_empty_flush_v1", W'(s_valid), W'(0));
    tick();
    check("t5_empty_flush_v2", W'(s_valid), W'(0));

    // Backpressure
    out_ready = 1'b0;
    push(32'h55); push(32'h66); push(32'h77); push(32'h88); push(32'h0A);
    repeat (4) begin
      tick();
      check("t3_deq", W'(s_deq), W'(1));
    end
    repeat (5) begin
      tick();
      check("t3_bp_valid", W'(s_valid), W'(1));
      check("t3_bp_data", s_data, pack4(32'h55, 32'h66, 32'h77, 32'h88));
      check("t3_bp_deq", W'(s_deq), W'(0));
    end
    out_ready = 1'b1;
    tick();
    check("t3_acc_valid", W'(s_valid), W'(1));
    check("t3_acc_data", s_data, pack4(32'h55, 32'h66, 32'h77, 32'h88));
    push(32'h0B); push(32'h0C);
    tick();
    check("t3_resume_deq", W'(s_deq), W'(1));
    tick();
    check("t4_deq_b", W'(s_deq), W'(1));

    // Partial flush
    flush = 1'b1;
    tick();
    check("t4_flush_nodeq", W'(s_deq), W'(0));
    flush = 1'b0;
    out_ready = 1'b0;
    tick();
    check("t4_valid", W'(s_valid), W'(1));
    check("t4_count", W'(s_count), W'(2));
    check("t4_last", W'(s_last), W'(1));
    check("t4_data", s_data, pack4(32'h0A, 32'h0B, 32'h0, 32'h0));

    // Flush during HOLD leaves the held beat alone, then dies on an empty accumulator
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("t5_hold_data", s_data, pack4(32'h0A, 32'h0B, 32'h0, 32'h0));
    check("t5_hold_count", W'(s_count), W'(2));
    check("t5_hold_last", W'(s_last), W'(1));
    out_ready = 1'b1;
    tick();
    tick();
    check("t5_pend_nodeq", W'(s_deq), W'(0));
    check("t5_pend_novalid", W'(s_valid), W'(0));
    tick();
    check("t5_deq_after", W'(s_deq), W'(1));

    // Mid-fill reset drops the partial words
    push(32'h0D);
    tick();
    RST_X = 1'b0;
    tick();
    check("t6_rst_deq", W'(s_deq), W'(0));
    RST_X = 1'b1;
    push(32'hE0); push(32'hE1); push(32'hE2); push(32'hE3);
    repeat (4) begin
      tick();
      check("t6_deq", W'(s_deq), W'(1));
    end
    tick();
    check("t6_valid", W'(s_valid), W'(1));
    check("t6_data", s_data, pack4(32'hE0, 32'hE1, 32'hE2, 32'hE3));
    check("t6_count", W'(s_count), W'(4));

    // Flush on the edge that would fill the last slot wins
    push(32'hF0); push(32'hF1); push(32'hF2);
    repeat (3) tick();
    push(32'hF3);
    flush = 1'b1;
    tick();
    check("lastslot_nodeq", W'(s_deq), W'(0));
    flush = 1'b0;
    tick();
    check("lastslot_valid", W'(s_valid), W'(1));
    check("lastslot_count", W'(s_count), W'(3));
    check("lastslot_last", W'(s_last), W'(1));
    check("lastslot_data", s_data, pack4(32'hF0, 32'hF1, 32'hF2, 32'h0));
    tick();
`ifdef AFIFO_PACK_STAT_EN
    check("stat_directed", W'(beat_cnt), W'(acc_total[15:0]));
`endif

    // Randomized traffic from a clean reset
    RST_X = 1'b0;
    fifo_q.delete();
    tick();
    RST_X = 1'b1;
    rand_mode = 1'b1;
    repeat (600) begin
      if ($urandom_range(2, 0) != 0) push($urandom());
      out_ready = ($urandom_range(3, 0) != 0);
      flush = ($urandom_range(9, 0) == 0);
      tick();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((fifo_q.size() > 0 || out_valid) && guard < 200) begin
      tick();
      guard++;
    end
    check("rand_drain_timeout", W'(guard < 200), W'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    check("rand_all_consumed", W'(sent_q.size()), W'(0));
`ifdef AFIFO_PACK_STAT_EN
    check("stat_random", W'(beat_cnt), W'(acc_total[15:0]));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
